// File: rtl/srm_pkg.sv
// srm_pkg: shared types for the save-RAM port arbiter.
// State encoding, requester IDs and a constant clog2 helper.
package srm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_ACK
  } state_e;

  localparam logic [1:0] REQ_CPU = 2'd0;
  localparam logic [1:0] REQ_SS  = 2'd1;
  localparam logic [1:0] REQ_EEP = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/srm_prio_sel.sv
// srm_prio_sel: 3-way priority select cpu > ss > eep with eep starvation override.
// Ports: req_i (bit per requester ID), starve_i; gnt_id_o, gnt_vld_o.
module srm_prio_sel
  import srm_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 3
) (
  input  logic [2:0]    req_i,
  input  logic [SW-1:0] starve_i,
  output logic [1:0]    gnt_id_o,
  output logic          gnt_vld_o
);

  always_comb begin
    gnt_id_o  = REQ_CPU;
    gnt_vld_o = |req_i;
    if (req_i[REQ_EEP] && starve_i == SW'(STARVE_MAX))
      gnt_id_o = REQ_EEP;
    else if (req_i[REQ_CPU])
      gnt_id_o = REQ_CPU;
    else if (req_i[REQ_SS])
      gnt_id_o = REQ_SS;
    else if (req_i[REQ_EEP])
      gnt_id_o = REQ_EEP;
  end

endmodule

// File: rtl/srm_port_arb.sv
// srm_port_arb: shares one 8-bit save-RAM port among CPU, save-state and EEPROM.
// Ports: {cpu,ss,eep}_{req,we,addr,wdat} in, _{ack,rdat} out; mem_* pins; busy.
module srm_port_arb
  import srm_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int RD_LAT     = 2,
  parameter int WR_CYC     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              map_rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdat,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdat,
  input  logic              eep_req,
  input  logic              eep_we,
  input  logic [ADDR_W-1:0] eep_addr,
  input  logic [7:0]        eep_wdat,
  output logic              eep_ack,
  output logic [7:0]        eep_rdat,
  input  logic              ss_req,
  input  logic              ss_we,
  input  logic [ADDR_W-1:0] ss_addr,
  input  logic [7:0]        ss_wdat,
  output logic              ss_ack,
  output logic [7:0]        ss_rdat,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              mem_oe,
  output logic              mem_we,
  output logic              busy
);

  localparam int CNT_MAX = (RD_LAT > WR_CYC + 1) ? RD_LAT : WR_CYC + 1;
  localparam int CW      = clog2(CNT_MAX + 1);
  localparam int SW0     = clog2(STARVE_MAX + 1);
  localparam int SW      = (SW0 < 1) ? 1 : SW0;

  if (RD_LAT < 1 || WR_CYC < 1) begin : g_param_chk
    $error("srm_port_arb: RD_LAT and WR_CYC must be >= 1");
  end

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          id_q;
  logic [SW-1:0]       starve_q;
  logic [2:0]          req_vec;
  logic [1:0]          gnt_id;
  logic                gnt_vld;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_wdat;

  assign req_vec = {eep_req, ss_req, cpu_req};

  srm_prio_sel #(
    .STARVE_MAX(STARVE_MAX),
    .SW        (SW)
  ) u_sel (
    .req_i    (req_vec),
    .starve_i (starve_q),
    .gnt_id_o (gnt_id),
    .gnt_vld_o(gnt_vld)
  );

  always_comb begin
    w_we   = cpu_we;
    w_addr = cpu_addr;
    w_wdat = cpu_wdat;
    unique case (gnt_id)
      REQ_SS: begin
        w_we   = ss_we;
        w_addr = ss_addr;
        w_wdat = ss_wdat;
      end
      REQ_EEP: begin
        w_we   = eep_we;
        w_addr = eep_addr;
        w_wdat = eep_wdat;
      end
      default: ;
    endcase
  end

  // WR: cnt 0 is the address/data setup cycle, cnt 1..WR_CYC strobe
  // mem_we. The ACK cycle that follows doubles as the trailing hold,
  // since mem_addr/mem_dout only move at the next grant.
  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      id_q     <= REQ_CPU;
      starve_q <= '0;
      mem_addr <= '0;
      mem_dout <= '0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      cpu_ack  <= 1'b0;
      ss_ack   <= 1'b0;
      eep_ack  <= 1'b0;
      cpu_rdat <= '0;
      ss_rdat  <= '0;
      eep_rdat <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ss_ack  <= 1'b0;
      eep_ack <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            id_q     <= gnt_id;
            mem_addr <= w_addr;
            mem_dout <= w_wdat;
            busy     <= 1'b1;
            cnt_q    <= '0;
            if (w_we) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
              mem_oe  <= 1'b1;
            end
          end
          if (!req_vec[REQ_EEP] || gnt_id == REQ_EEP)
            starve_q <= '0;
          else if (starve_q != SW'(STARVE_MAX))
            starve_q <= starve_q + 1'b1;
        end
        S_RD: begin
          if (cnt_q == CW'(RD_LAT - 1)) begin
            mem_oe  <= 1'b0;
            state_q <= S_ACK;
            unique case (id_q)
              REQ_SS: begin
                ss_rdat <= mem_din;
                ss_ack  <= 1'b1;
              end
              REQ_EEP: begin
                eep_rdat <= mem_din;
                eep_ack  <= 1'b1;
              end
              default: begin
                cpu_rdat <= mem_din;
                cpu_ack  <= 1'b1;
              end
            endcase
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WR: begin
          if (cnt_q == CW'(WR_CYC)) begin
            mem_we  <= 1'b0;
            state_q <= S_ACK;
            unique case (id_q)
              REQ_SS:  ss_ack  <= 1'b1;
              REQ_EEP: eep_ack <= 1'b1;
              default: cpu_ack <= 1'b1;
            endcase
          end else begin
            mem_we <= 1'b1;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srm_port_arb.sv
// tb_srm_port_arb: random + directed traffic against a transaction-level model.
// Predictor pushes expected grants; a monitor pops and checks on every ack.
module tb_srm_port_arb;

  localparam int AW     = 13;
  localparam int RD_LAT = 2;
  localparam int WR_CYC = 2;
  localparam int SMAX   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]    req = '0;
  logic [2:0]    we = '0;
  logic [AW-1:0] addr[3];
  logic [7:0]    wdat[3];
  logic [2:0]    ack;
  logic [7:0]    rdat[3];
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din;
  logic          mem_oe;
  logic          mem_we;
  logic          busy;

  srm_port_arb #(
    .ADDR_W(AW), .RD_LAT(RD_LAT), .WR_CYC(WR_CYC), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .map_rst_n(rst_n),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]),
    .cpu_wdat(wdat[0]), .cpu_ack(ack[0]), .cpu_rdat(rdat[0]),
    .eep_req(req[2]), .eep_we(we[2]), .eep_addr(addr[2]),
    .eep_wdat(wdat[2]), .eep_ack(ack[2]), .eep_rdat(rdat[2]),
    .ss_req(req[1]), .ss_we(we[1]), .ss_addr(addr[1]),
    .ss_wdat(wdat[1]), .ss_ack(ack[1]), .ss_rdat(rdat[1]),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_oe(mem_oe), .mem_we(mem_we), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory model: data valid only once mem_oe has been high RD_LAT cycles
  logic [7:0] mem[2**AW];
  logic [7:0] ref_mem[2**AW];
  int oe_cnt = 0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_dout;
    oe_cnt <= mem_oe ? oe_cnt + 1 : 0;
  end
  assign mem_din = (mem_oe && oe_cnt >= RD_LAT - 1) ? mem[mem_addr]
                                                   : ~mem[mem_addr];

  // pin-level strobe checks
  logic [AW-1:0] l_addr = '0;
  logic [7:0]    l_dout = '0;
  logic          l_we = 1'b0;
  logic          l_oe = 1'b0;
  int wrun = 0;
  int orun = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      wrun = 0;
      orun = 0;
      l_we = 1'b0;
      l_oe = 1'b0;
    end else begin
      if (mem_we) begin
        chk("we_addr_stable", mem_addr, l_addr);
        chk("we_dout_stable", mem_dout, l_dout);
        wrun++;
      end else if (l_we) begin
        chk("we_len", wrun, WR_CYC);
        chk("we_addr_hold", mem_addr, l_addr);
        chk("we_dout_hold", mem_dout, l_dout);
        wrun = 0;
      end
      if (mem_oe) orun++;
      else if (l_oe) begin
        chk("oe_len", orun, RD_LAT);
        orun = 0;
      end
      if (mem_we && mem_oe) chk("we_oe_excl", 1, 0);
      l_we = mem_we;
      l_oe = mem_oe;
    end
    l_addr = mem_addr;
    l_dout = mem_dout;
  end

  // predictor: arbitrates with the priority/starvation rules
  typedef struct {
    int id;
    bit we;
    int addr;
    int wdat;
    int ack_cyc;
  } txn_t;
  txn_t q[$];
  int free_at = 0;
  int starve = 0;

  always @(negedge clk) begin : pred
    txn_t t;
    int w;
    int lat;
    if (!rst_n) begin
      q.delete();
      free_at = 0;
      starve = 0;
    end else begin
      chk("busy", int'(busy), int'(cyc < free_at));
      if (cyc >= free_at) begin
        w = -1;
        if (req[2] && starve == SMAX) w = 2;
        else if (req[0]) w = 0;
        else if (req[1]) w = 1;
        else if (req[2]) w = 2;
        if (!req[2] || w == 2) starve = 0;
        else if (starve < SMAX) starve++;
        if (w >= 0) begin
          lat = we[w] ? WR_CYC + 2 : RD_LAT + 1;
          t.id = w;
          t.we = we[w];
          t.addr = int'(addr[w]);
          t.wdat = int'(wdat[w]);
          t.ack_cyc = cyc + lat;
          q.push_back(t);
          free_at = cyc + lat + 1;
        end
      end
    end
  end

  // monitor: pops on each ack
  logic [7:0] exp_rdat[3];
  always @(negedge clk) begin : mon
    txn_t t;
    if (!rst_n) begin
      exp_rdat = '{8'h00, 8'h00, 8'h00};
      chk("ack_in_reset", int'(ack), 0);
    end else begin
      if (ack != 3'b000) begin
        chk("ack_onehot", $countones(ack), 1);
        if (q.size() == 0) chk("ack_unexpected", int'(ack), 0);
        else begin
          t = q.pop_front();
          chk("ack_id", int'(ack), 1 << t.id);
          chk("ack_cycle", cyc, t.ack_cyc);
          if (t.we) ref_mem[t.addr] = 8'(t.wdat);
          else exp_rdat[t.id] = ref_mem[t.addr];
        end
      end
      for (int r = 0; r < 3; r++)
        chk($sformatf("rdat%0d", r), int'(rdat[r]), int'(exp_rdat[r]));
    end
  end

  // random requesters
  bit rand_en = 1'b0;
  int prob[3];

  task automatic issue(input int r, input bit w, input int a, input int d);
    we[r] = w;
    addr[r] = AW'(a);
    wdat[r] = 8'(d);
    req[r] = 1'b1;
  endtask

  task automatic new_txn(input int r);
    issue(r, 1'($urandom_range(1)), int'($urandom_range(15)),
          int'($urandom_range(255)));
  endtask

  always begin : drv
    @(posedge clk);
    #1;
    if (rand_en && rst_n) begin
      for (int r = 0; r < 3; r++) begin
        if (ack[r]) begin
          if (int'($urandom_range(99)) < prob[r]) new_txn(r);
          else req[r] = 1'b0;
        end else if (!req[r] && int'($urandom_range(99)) < prob[r]) begin
          new_txn(r);
        end
      end
    end
  end

  task automatic wait_ack(input int r);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack[r] && n < 200);
    if (!ack[r]) chk($sformatf("ack_timeout%0d", r), 0, 1);
    req[r] = 1'b0;
  endtask

  task automatic drain();
    rand_en = 1'b0;
    for (int r = 0; r < 3; r++)
      if (req[r]) wait_ack(r);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_oe"}, int'(mem_oe), 0);
    chk({tag, "_we"}, int'(mem_we), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_dout"}, int'(mem_dout), 0);
    for (int r = 0; r < 3; r++)
      chk($sformatf("%s_rdat%0d", tag, r), int'(rdat[r]), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int a;
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = 8'($urandom_range(255));
      ref_mem[i] = mem[i];
    end
    for (int r = 0; r < 3; r++) begin
      addr[r] = '0;
      wdat[r] = '0;
      prob[r] = 50;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single CPU read
    mem[13'h0123] = 8'h5A;
    ref_mem[13'h0123] = 8'h5A;
    a = cyc;
    issue(0, 1'b0, 13'h0123, 0);
    wait_ack(0);
    chk("t1_lat", cyc - a, RD_LAT + 1);
    chk("t1_rdat", int'(rdat[0]), 8'h5A);
    repeat (2) @(posedge clk);
    #1;

    // EEP write
    a = cyc;
    issue(2, 1'b1, 13'h0007, 8'hC3);
    wait_ack(2);
    chk("t2_lat", cyc - a, WR_CYC + 2);
    chk("t2_mem", int'(mem[13'h0007]), 8'hC3);
    repeat (2) @(posedge clk);
    #1;

    // all three at once
    issue(0, 1'b0, 13'h0010, 0);
    issue(1, 1'b1, 13'h0011, 8'hA5);
    issue(2, 1'b0, 13'h0011, 0);
    fork
      wait_ack(0);
      wait_ack(1);
      wait_ack(2);
    join
    chk("t3_eep_rdat", int'(rdat[2]), 8'hA5);
    repeat (2) @(posedge clk);
    #1;

    // ss request arriving in the cpu ACK cycle
    issue(0, 1'b0, 13'h0020, 0);
    wait_ack(0);
    a = cyc;
    issue(1, 1'b0, 13'h0020, 0);
    wait_ack(1);
    chk("t6_lat", cyc - a, RD_LAT + 2);
    chk("t6_same", int'(rdat[1]), int'(rdat[0]));
    repeat (2) @(posedge clk);
    #1;

    // random mixed traffic
    prob = '{50, 50, 50};
    rand_en = 1'b1;
    repeat (3000) @(posedge clk);
    #1;
    drain();

    // starvation: cpu always requesting, eep pending
    prob = '{100, 0, 100};
    rand_en = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    drain();

    // reset during the first write strobe cycle
    issue(2, 1'b1, 13'h0005, 8'h99);
    a = 0;
    do begin
      @(posedge clk);
      #1;
      a++;
    end while (!mem_we && a < 20);
    chk("t5_saw_we", int'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t5");
    req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(2, 1'b1, 13'h0005, 8'h99);
    wait_ack(2);
    issue(2, 1'b0, 13'h0005, 0);
    wait_ack(2);
    chk("t5_readback", int'(rdat[2]), 8'h99);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
